// File: rtl/fir_out_pkg.sv
// Shared constants and arithmetic helpers for the FIR output conditioner:
// round-half-up shift and saturation to the output sample width.
package fir_out_pkg;

  localparam int IN_W_DEF  = 48;
  localparam int OUT_W_DEF = 16;

  typedef logic signed [IN_W_DEF:0]    wide_t;
  typedef logic signed [OUT_W_DEF-1:0] sample_t;

  localparam sample_t SAT_MAX = 16'sh7FFF;
  localparam sample_t SAT_MIN = 16'sh8000;

  // One guard bit above the input width keeps the rounding add from wrapping.
  function automatic wide_t round_shift(input logic signed [IN_W_DEF-1:0] value,
                                        input int unsigned shift);
    wide_t sum;
    sum = wide_t'(value) + (49'sd1 <<< (shift - 32'd1));
    return sum >>> shift;
  endfunction

  function automatic sample_t sat_to_out(input wide_t value, output logic clip_flag);
    sample_t res;
    if (value > wide_t'(SAT_MAX)) begin
      clip_flag = 1'b1;
      res       = SAT_MAX;
    end else if (value < wide_t'(SAT_MIN)) begin
      clip_flag = 1'b1;
      res       = SAT_MIN;
    end else begin
      clip_flag = 1'b0;
      res       = sample_t'(value);
    end
    return res;
  endfunction

endpackage

// File: rtl/fir_out_conditioner_if.sv
// Sample stream interface: FIR result/strobe in, FWFT valid/ready sample out.
interface fir_out_conditioner_if #(
  parameter int IN_W  = 48,
  parameter int OUT_W = 16
) ();
  logic signed [IN_W-1:0]  in_val;
  logic                    in_strobe;
  logic signed [OUT_W-1:0] out_data;
  logic                    out_valid;
  logic                    out_ready;

  modport master (output in_val, in_strobe, out_ready, input out_data, out_valid);
  modport slave  (input in_val, in_strobe, out_ready, output out_data, out_valid);
endinterface

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through synchronous FIFO; head_data shows mem[rd_ptr] directly.
// A push into a full FIFO is accepted only when a pop frees the slot in the same cycle.
module sync_fifo_fwft #(
  parameter int DATA_W = 16,
  parameter int AW     = 2
) (
  input  logic              clk,
  input  logic              nreset,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head_data,
  output logic [AW:0]       level,
  output logic              full,
  output logic              empty
);

  localparam logic [AW:0] DEPTH_L = {1'b1, {AW{1'b0}}};

  logic [DATA_W-1:0] mem_r [0:(1<<AW)-1];
  logic [AW-1:0]     wr_ptr_r;
  logic [AW-1:0]     rd_ptr_r;
  logic [AW:0]       level_r;
  logic              push_s;
  logic              pop_s;

  assign empty     = (level_r == {(AW+1){1'b0}});
  assign full      = (level_r == DEPTH_L);
  assign level     = level_r;
  assign head_data = mem_r[rd_ptr_r];
  assign pop_s     = pop & ~empty;
  assign push_s    = push & (~full | pop_s);

  // Storage array, written only on an accepted push.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (!nreset) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      level_r  <= {(AW+1){1'b0}};
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + AW'(1'b1);
      if (pop_s)  rd_ptr_r <= rd_ptr_r + AW'(1'b1);
      case ({push_s, pop_s})
        2'b10:   level_r <= level_r + {{AW{1'b0}}, 1'b1};
        2'b01:   level_r <= level_r - {{AW{1'b0}}, 1'b1};
        default: level_r <= level_r;
      endcase
    end
  end

endmodule

// File: rtl/fir_out_conditioner.sv
// Rounds/scales/saturates 48-bit FIR results to 16-bit samples, buffers them in a
// FWFT FIFO and keeps clip/overflow statistics. Peak tracking needs FIR_OUT_PEAK_EN.
module fir_out_conditioner
  import fir_out_pkg::*;
#(
  parameter int IN_W    = IN_W_DEF,
  parameter int OUT_W   = OUT_W_DEF,
  parameter int SHIFT   = 15,
  parameter int FIFO_AW = 2
) (
  input  logic                    clk,
  input  logic                    nreset,
  fir_out_conditioner_if.slave    bus,
  output logic [FIFO_AW:0]        fifo_level,
  input  logic                    clr_stats,
  output logic [15:0]             clip_cnt,
  output logic [7:0]              ovf_cnt,
  output logic signed [OUT_W-1:0] peak_abs
);

  logic signed [IN_W-1:0]  in_s;
  wide_t                   a_r_r;
  logic                    a_vld_r;
  logic signed [OUT_W-1:0] sat_s;
  logic                    clip_s;
  logic                    full_s;
  logic                    empty_s;
  logic                    pop_s;
  logic                    drop_s;
  logic [15:0]             clip_cnt_r;
  logic [7:0]              ovf_cnt_r;

  assign in_s = bus.in_val;

  // Stage A: round-half-up and scale each strobed result.
  always_ff @(posedge clk) begin
    if (!nreset) begin
      a_vld_r <= 1'b0;
      a_r_r   <= '0;
    end else begin
      a_vld_r <= bus.in_strobe;
      if (bus.in_strobe) begin
        a_r_r <= round_shift(IN_W_DEF'(in_s), unsigned'(SHIFT));
      end
    end
  end

  // Stage B: saturate the rounded value; the result feeds the FIFO push directly.
  always_comb begin
    clip_s = 1'b0;
    sat_s  = sat_to_out(a_r_r, clip_s);
  end

  assign pop_s  = bus.out_ready & ~empty_s;
  assign drop_s = a_vld_r & full_s & ~pop_s;

  sync_fifo_fwft #(
    .DATA_W (OUT_W),
    .AW     (FIFO_AW)
  ) u_fifo (
    .clk       (clk),
    .nreset    (nreset),
    .push      (a_vld_r),
    .push_data (sat_s),
    .pop       (bus.out_ready),
    .head_data (bus.out_data),
    .level     (fifo_level),
    .full      (full_s),
    .empty     (empty_s)
  );

  assign bus.out_valid = ~empty_s;

  // Saturating clip and overflow counters; a clear wins over a same-cycle increment.
  always_ff @(posedge clk) begin
    if (!nreset) begin
      clip_cnt_r <= 16'h0000;
      ovf_cnt_r  <= 8'h00;
    end else if (clr_stats) begin
      clip_cnt_r <= 16'h0000;
      ovf_cnt_r  <= 8'h00;
    end else begin
      if (a_vld_r && clip_s && clip_cnt_r != 16'hFFFF) clip_cnt_r <= clip_cnt_r + 16'h0001;
      if (drop_s && ovf_cnt_r != 8'hFF)                ovf_cnt_r  <= ovf_cnt_r + 8'h01;
    end
  end

  assign clip_cnt = clip_cnt_r;
  assign ovf_cnt  = ovf_cnt_r;

`ifdef FIR_OUT_PEAK_EN
  logic signed [OUT_W-1:0] abs_s;
  logic signed [OUT_W-1:0] peak_r;

  // |-32768| has no positive representation, so it folds to the positive limit.
  always_comb begin
    if (sat_s == SAT_MIN) begin
      abs_s = SAT_MAX;
    end else if (sat_s[OUT_W-1]) begin
      abs_s = -sat_s;
    end else begin
      abs_s = sat_s;
    end
  end

  // Peak tracks every push attempt, including ones dropped on a full FIFO.
  always_ff @(posedge clk) begin
    if (!nreset) begin
      peak_r <= {OUT_W{1'b0}};
    end else if (clr_stats) begin
      peak_r <= {OUT_W{1'b0}};
    end else if (a_vld_r && abs_s > peak_r) begin
      peak_r <= abs_s;
    end
  end

  assign peak_abs = peak_r;
`else
  assign peak_abs = {OUT_W{1'b0}};
`endif

endmodule

// File: doc/fir_out_conditioner.md
Name: fir_out_conditioner

Overview:
Sits directly downstream of the 512-tap FIR filter stage. Consumes its 48-bit signed accumulator result and the one-cycle ready strobe that accompanies it. Rounds, scales and saturates each result to a 16-bit signed audio sample, then buffers the samples in a small first-word-fall-through FIFO with a valid/ready handshake for the capture/output logic. Also keeps clip and overflow statistics for the host.

Parameters:
IN_W, 48, input accumulator width (signed)
OUT_W, 16, output sample width (signed)
SHIFT, 15, arithmetic right shift applied after rounding (Q15 coefficients); legal range 1..IN_W-OUT_W
FIFO_AW, 2, FIFO address width; depth = 2**FIFO_AW

Ports:
clk  in  1  single system clock
nreset  in  1  reset, synchronous, active-low
in_val  in  IN_W  signed FIR result; sampled only when in_strobe=1
in_strobe  in  1  one-cycle qualifier for in_val (FIR out_ready)
out_data  out  OUT_W  signed sample at FIFO head; meaningful only when out_valid=1
out_valid  out  1  FIFO non-empty
out_ready  in  1  consumer accepts head when out_valid & out_ready at an edge
fifo_level  out  FIFO_AW+1  current FIFO occupancy, 0..2**FIFO_AW
clr_stats  in  1  one-cycle clear of clip_cnt, ovf_cnt, peak_abs
clip_cnt  out  16  saturating count of clipped samples
ovf_cnt  out  8  saturating count of samples dropped on FIFO full
peak_abs  out  OUT_W  peak absolute sample value since last clear (see Optional Feature)

Behaviour:
- Reset (nreset=0 at an edge): pipeline and FIFO are flushed; all in-flight samples are discarded. Outputs reset to: out_valid=0, fifo_level=0, clip_cnt=0, ovf_cnt=0, peak_abs=0.
- Stage A (edge k, when in_strobe=1): r = (in_val + 2**(SHIFT-1)) >>> SHIFT.
  - Addition is done in IN_W+1 bits, so there is no wrap.
  - Rounding is round-half-up: ties round toward +inf.
  - A valid flag is registered alongside r.
- Stage B (edge k+1, when stage-A valid): saturate r to OUT_W.
  - r > 2**(OUT_W-1)-1 gives 32767; r < -2**(OUT_W-1) gives -32768.
  - On a clip, clip_cnt increments, saturating at 0xFFFF.
  - The saturated sample is pushed into the FIFO.
  - out_valid is visible after edge k+1, so latency from strobe to output is 2 clocks.
- in_strobe may be asserted every cycle; the pipeline is fully pipelined with no stall.
- FIFO is first-word-fall-through: out_data = mem[rd_ptr] combinationally. Pop occurs on out_valid & out_ready.
- Push while full:
  - With no pop in the same cycle, the new sample is dropped, ovf_cnt increments (saturating at 0xFF), and FIFO contents are unchanged.
  - With a pop in the same cycle, the push is accepted and fifo_level stays at 2**FIFO_AW.
- Push and pop together when not full: fifo_level is unchanged. Pop while empty is ignored.
- Pointers wrap modulo 2**FIFO_AW; full/empty are derived from fifo_level.
- clr_stats: clear wins over any increment or peak update in the same cycle, so the counter reads 0 after that edge.
- out_ready is ignored while out_valid=0. out_data must stay stable while out_valid=1 and out_ready=0.

Optional Feature:
- Macro: FIR_OUT_PEAK_EN
- Defined: on each FIFO push (including a dropped push), peak_abs is updated to max(peak_abs, |sample|). |-32768| saturates to 32767. The register is cleared by clr_stats and by reset.
- Undefined: peak_abs is tied to 0, and no comparator or register is synthesised.

Decomposition:
- Package fir_out_pkg holds:
  - constants IN_W_DEF=48, OUT_W_DEF=16, SAT_MAX=32767, SAT_MIN=-32768;
  - function round_shift(value, shift);
  - function sat_to_out(value, clip_flag).
- One sub-module, sync_fifo_fwft:
  - parameters DATA_W, AW;
  - ports: push, push_data, pop, head_data, level, full, empty.
  - It is reused by the capture path.
- Rounding, saturation, counters and peak logic live in fir_out_conditioner.

Test Plan:
1. in_val=32768000 with strobe at edge k -> out_valid rises after edge k+1, out_data=1000, clip_cnt=0.
2. Rounding, with out_ready=1:
   - in_val=16384 -> 1; 16383 -> 0; -16384 -> 0; -16385 -> -1.
   - One sample per cycle, back-to-back -> four consecutive outputs in order.
3. Saturation: in_val=2**47-1 -> 32767; in_val=-2**47 -> -32768; clip_cnt=2.
   - Then clr_stats coincident with a third clipping sample -> clip_cnt=0.
4. Overflow: out_ready=0, six strobes with values 1..6 (scaled by 2**15) -> fifo_level=4, ovf_cnt=2.
   - Drain -> outputs 1,2,3,4, then out_valid=0.
5. Full plus simultaneous pop and push: FIFO holds 1..4, push 5 with out_ready=1 -> head 1 popped, level stays 4.
   - Subsequent drain -> 2,3,4,5; ovf_cnt=0.
6. With FIR_OUT_PEAK_EN: samples 100, -2000, 500 -> peak_abs=2000; then -32768 -> peak_abs=32767.
   - nreset=0 for one edge mid-stream, with 3 samples queued and 1 in flight -> out_valid=0, level=0, all statistics 0, and the in-flight sample never appears.
